// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: prioritised stall/flush sequencer for the five-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_mdu_start,
  input  logic       ex_mdu_is_div,
  input  logic       ex_redirect,
  input  logic       mem_exception,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       pc_stall,
  output logic       f2d_stall,
  output logic       f2d_flush,
  output logic       d2e_stall,
  output logic       d2e_flush,
  output logic       e2m_stall,
  output logic       e2m_flush,
  output logic       global_flush,
  output logic       mdu_busy,
  output logic [1:0] state
);
  localparam logic [1:0] RUN = 2'd0, MDU_WAIT = 2'd1, EXC_FLUSH = 2'd2;
  logic [1:0] st, st_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic redirect_pend, rp_nxt;
  logic exc, dwait, mdu_start, mdu_stall, redir, load_use, act;
  logic d, m, r, l, i;
  assign act       = ~rst;
  assign exc       = mem_exception | (st == EXC_FLUSH);
  assign dwait     = ~dmem_ready;
  assign mdu_start = (st == RUN) & ex_mdu_start;
  assign mdu_stall = mdu_start | ((st == MDU_WAIT) & (cnt != '0));
  assign redir     = ex_redirect | redirect_pend;
  assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));
  assign d = act & ~exc & dwait;
  assign m = act & ~exc & ~dwait & mdu_stall;
  assign r = act & ~exc & ~dwait & ~mdu_stall & redir;
  assign l = act & ~exc & ~dwait & ~mdu_stall & ~redir & load_use;
  assign i = act & ~exc & ~dwait & ~mdu_stall & ~redir & ~load_use & ~imem_ready;
  assign pc_stall     = d | m | l | i;
  assign f2d_stall    = d | m | l;
  assign d2e_stall    = d | m;
  assign e2m_stall    = d;
  assign f2d_flush    = r | i;
  assign d2e_flush    = r | l;
  assign e2m_flush    = m;
  assign global_flush = act & exc;
  assign mdu_busy     = act & (st == MDU_WAIT);
  assign state        = act ? st : RUN;
  always_comb begin
    st_nxt  = mem_exception ? EXC_FLUSH :
              (st == EXC_FLUSH) ? RUN :
              (st == RUN) ? (ex_mdu_start ? MDU_WAIT : RUN) :
              ((cnt == '0) ? RUN : MDU_WAIT);
    cnt_nxt = mem_exception ? '0 :
              mdu_start ? (ex_mdu_is_div ? CNT_WIDTH'(DIV_CYCLES - 1) : CNT_WIDTH'(MUL_CYCLES - 1)) :
              ((st == MDU_WAIT) & (cnt != '0)) ? cnt - CNT_WIDTH'(1) : cnt;
    rp_nxt  = ~exc & redir & (dwait | mdu_stall);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st            <= RUN;
      cnt           <= '0;
      redirect_pend <= 1'b0;
    end else begin
      st            <= st_nxt;
      cnt           <= cnt_nxt;
      redirect_pend <= rp_nxt;
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed table vectors plus multi-cycle sequences
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_rs_used, id_rt_used, ex_mem_read, ex_mdu_start, ex_mdu_is_div;
  logic ex_redirect, mem_exception, imem_ready, dmem_ready;
  logic pc_stall, f2d_stall, f2d_flush, d2e_stall, d2e_flush, e2m_stall, e2m_flush;
  logic global_flush, mdu_busy;
  logic [1:0] state;
  logic [8:0] outs;
  int errors = 0, checks = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_mdu_start(ex_mdu_start), .ex_mdu_is_div(ex_mdu_is_div), .ex_redirect(ex_redirect),
    .mem_exception(mem_exception), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .f2d_stall(f2d_stall), .f2d_flush(f2d_flush),
    .d2e_stall(d2e_stall), .d2e_flush(d2e_flush), .e2m_stall(e2m_stall),
    .e2m_flush(e2m_flush), .global_flush(global_flush), .mdu_busy(mdu_busy), .state(state)
  );

  always #5 clk = ~clk;

  // bit order: pc_s f2d_s f2d_f d2e_s d2e_f e2m_s e2m_f gflush busy
  assign outs = {pc_stall, f2d_stall, f2d_flush, d2e_stall, d2e_flush,
                 e2m_stall, e2m_flush, global_flush, mdu_busy};

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       rsu, rtu, mr;
    logic [4:0] rd;
    logic       rdr, im, dm;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic rsu, logic rtu,
                              logic mr, logic [4:0] rd, logic rdr, logic im, logic dm,
                              logic [8:0] e);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.rsu = rsu; v.rtu = rtu; v.mr = mr;
    v.rd = rd; v.rdr = rdr; v.im = im; v.dm = dm; v.exp = e;
    return v;
  endfunction

  task automatic chk(string n, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; ex_mem_read = 1'b0;
    ex_mdu_start = 1'b0; ex_mdu_is_div = 1'b0; ex_redirect = 1'b0;
    mem_exception = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pc_cnt, busy_cnt;
    tbl[0]  = mk("lu_rs",      5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 9'b110010000);
    tbl[1]  = mk("lu_rd0",     5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 9'b000000000);
    tbl[2]  = mk("lu_rt",      5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 9'b110010000);
    tbl[3]  = mk("lu_rt_unused", 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 9'b000000000);
    tbl[4]  = mk("no_load",    5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1, 9'b000000000);
    tbl[5]  = mk("imem_wait",  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 9'b101000000);
    tbl[6]  = mk("redirect",   5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 9'b001010000);
    tbl[7]  = mk("redir_lu",   5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 9'b001010000);
    tbl[8]  = mk("lu_imem",    5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 9'b110010000);
    tbl[9]  = mk("dmem_wait",  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 9'b110101000);
    tbl[10] = mk("idle",       5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 9'b000000000);
    tbl[11] = mk("dmem_lu",    5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 9'b110101000);
    tbl[12] = mk("redir_imem", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 9'b001010000);

    // reset with a live load-use hazard on the inputs: outputs must stay 0
    idle();
    id_rs = 5'd5; id_rs_used = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; imem_ready = 1'b0;
    #3;
    chk("reset_outs", outs, 9'd0);
    chk("reset_state", {7'd0, state}, 9'd0);
    next(); next();
    rst = 1'b0;
    idle();

    foreach (tbl[k]) begin
      id_rs = tbl[k].rs; id_rt = tbl[k].rt; id_rs_used = tbl[k].rsu; id_rt_used = tbl[k].rtu;
      ex_mem_read = tbl[k].mr; ex_rd = tbl[k].rd; ex_redirect = tbl[k].rdr;
      imem_ready = tbl[k].im; dmem_ready = tbl[k].dm;
      @(negedge clk);
      chk(tbl[k].name, outs, tbl[k].exp);
      chk({tbl[k].name, "_state"}, {7'd0, state}, 9'd0);
      next();
    end
    idle();

    // divide: 32 stalled cycles, 32 busy cycles, RUN the cycle after cnt hits 0
    pc_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      ex_mdu_start = (k == 0); ex_mdu_is_div = 1'b1;
      @(negedge clk);
      pc_cnt += int'(pc_stall);
      busy_cnt += int'(mdu_busy);
      if (k == 31) chk("div_last_stall", outs, 9'b110100101);
      if (k == 32) chk("div_release", outs, 9'b000000001);
      if (k == 33) chk("div_state_run", {7'd0, state}, 9'd0);
      next();
    end
    chk("div_pc_cycles", 9'(pc_cnt), 9'd32);
    chk("div_busy_cycles", 9'(busy_cnt), 9'd32);
    idle();

    // multiply with exception on its 2nd cycle
    ex_mdu_start = 1'b1;
    @(negedge clk); chk("mul_start", outs, 9'b110100100);
    next(); ex_mdu_start = 1'b0; mem_exception = 1'b1;
    @(negedge clk); chk("mul_exc_raise", outs, 9'b000000011);
    next(); mem_exception = 1'b0;
    @(negedge clk); chk("mul_exc_flush", outs, 9'b000000010);
    chk("mul_exc_state", {7'd0, state}, 9'd2);
    next();
    @(negedge clk); chk("mul_exc_done", outs, 9'd0);
    chk("mul_exc_state_run", {7'd0, state}, 9'd0);
    next();

    // exception raised again while in EXC_FLUSH extends it by one cycle
    mem_exception = 1'b1;
    @(negedge clk); chk("exc2_a", outs, 9'b000000010);
    next();
    @(negedge clk); chk("exc2_b", outs, 9'b000000010);
    next(); mem_exception = 1'b0;
    @(negedge clk); chk("exc2_c", {7'd0, state}, 9'd2);
    next();
    @(negedge clk); chk("exc2_run", {outs[8:2], state}, 9'd0);
    next();

    // redirect held behind dmem wait, applied on the first ready cycle
    ex_redirect = 1'b1; dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("redir_dwait", outs, 9'b110101000);
      next();
    end
    ex_redirect = 1'b0; dmem_ready = 1'b1;
    @(negedge clk); chk("redir_pend_apply", outs, 9'b001010000);
    next();
    @(negedge clk); chk("redir_pend_cleared", outs, 9'd0);
    next();

    // imem wait for two cycles
    imem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); chk("imem_wait_seq", outs, 9'b101000000);
      next();
    end
    imem_ready = 1'b1;

    // redirect with multiply start; repeated start while busy is ignored
    ex_redirect = 1'b1; ex_mdu_start = 1'b1;
    @(negedge clk); chk("mdu_redir_start", outs, 9'b110100100);
    next(); ex_redirect = 1'b0; ex_mdu_is_div = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); chk("mdu_redir_wait", outs, 9'b110100101);
      next();
    end
    @(negedge clk); chk("mdu_redir_release", outs, 9'b001010001);
    next(); idle();
    @(negedge clk); chk("mdu_redir_done", {outs, 2'b00} == 11'd0 ? {7'd0, state} : 9'h1ff, 9'd0);
    next();

    // async reset mid-divide at cnt 10
    ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b1;
    next(); ex_mdu_start = 1'b0;
    for (int k = 0; k < 21; k++) next();
    id_rs = 5'd5; id_rs_used = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; ex_redirect = 1'b1;
    @(negedge clk); chk("pre_reset_busy", outs, 9'b110100101);
    #2 rst = 1'b1;
    #1 chk("async_reset_outs", outs, 9'd0);
    chk("async_reset_state", {7'd0, state}, 9'd0);
    next(); idle(); rst = 1'b0;
    @(negedge clk); chk("post_reset", outs, 9'd0);
    chk("post_reset_state", {7'd0, state}, 9'd0);
    next();
    @(negedge clk); chk("post_reset_busy", {8'd0, mdu_busy}, 9'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
